// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, requester ids and
// the byte-to-word address offset.
package mem_arb_pkg;
  typedef enum logic {ST_IDLE, ST_BUSY} arb_state_t;
  typedef enum logic {REQ_I, REQ_D} req_id_t;
  localparam int WORD_OFF = 2;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is the fetch port, bit 1 the load/store port.
// On a tie the port that did not win last time is granted.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       grant_en,
  input  logic       rr_last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (grant_en) begin
      if (req == 2'b11) gnt = (rr_last == REQ_I) ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port unified memory between the core's fetch and load/store
// ports: round-robin grant, one outstanding access, fixed-latency response.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_resp_valid,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [DATA_W/8-1:0]   d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_resp_valid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_en,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [ADDR_W-3:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_t       state, state_nxt;
  req_id_t          owner, rr_last;
  logic             owner_st;
  logic [LAT_W-1:0] lat_cnt;
  logic [1:0]       gnt;
  logic             grant_en, any_gnt, resp_fire, both_valid;
  logic             unused_addr_lsb;

  // Alignment is guaranteed by the core; the byte offset bits are dropped.
  assign unused_addr_lsb = ^{i_addr[WORD_OFF-1:0], d_addr[WORD_OFF-1:0]};

  // Grants are suppressed while reset is high so every strobe reads 0 in that cycle.
  assign grant_en   = (state == ST_IDLE) && !rst;
  assign any_gnt    = |gnt;
  assign both_valid = i_req_valid && d_req_valid;
  assign resp_fire  = (state == ST_BUSY) && (lat_cnt == '0) && !rst;

  rr_arb2 u_rr (
    .req      ({d_req_valid, i_req_valid}),
    .grant_en (grant_en),
    .rr_last  (rr_last),
    .gnt      (gnt)
  );

  always_comb begin
    state_nxt    = state;
    i_req_ready  = gnt[REQ_I];
    d_req_ready  = gnt[REQ_D];
    mem_en       = any_gnt;
    mem_we       = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    i_resp_valid = 1'b0;
    d_resp_valid = 1'b0;
    i_rdata      = '0;
    d_rdata      = '0;

    if (gnt[REQ_D]) begin
      mem_we    = d_we;
      mem_addr  = d_addr[ADDR_W-1:WORD_OFF];
      mem_wdata = d_wdata;
    end else if (gnt[REQ_I]) begin
      mem_addr  = i_addr[ADDR_W-1:WORD_OFF];
    end

    if (resp_fire) begin
      if (owner == REQ_I) begin
        i_resp_valid = 1'b1;
        i_rdata      = mem_rdata;
      end else begin
        d_resp_valid = 1'b1;
        // Store completions carry no data.
        d_rdata      = owner_st ? '0 : mem_rdata;
      end
    end

    case (state)
      ST_IDLE: if (any_gnt) state_nxt = ST_BUSY;
      ST_BUSY: if (lat_cnt == '0) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      owner        <= REQ_I;
      rr_last      <= REQ_I;
      owner_st     <= 1'b0;
      lat_cnt      <= '0;
      conflict_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (any_gnt) begin
        owner    <= gnt[REQ_D] ? REQ_D : REQ_I;
        rr_last  <= gnt[REQ_D] ? REQ_D : REQ_I;
        owner_st <= gnt[REQ_D] && (|d_we);
        lat_cnt  <= LAT_W'(MEM_LAT - 1);
      end else if (state == ST_BUSY && lat_cnt != '0) begin
        lat_cnt  <= lat_cnt - LAT_W'(1);
      end
      if (state == ST_IDLE && both_valid && conflict_cnt != {CNT_W{1'b1}})
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: one arbiter with MEM_LAT=1, one with MEM_LAT=3 and a 2-bit
// conflict counter, each in front of a small behavioural memory.
module tb_mem_arbiter;
  logic clk;
  int checks = 0;
  int errors = 0;

  // ---------------- DUT A: MEM_LAT=1 ----------------
  logic        a_rst, a_i_valid, a_i_ready, a_i_resp, a_d_valid, a_d_ready, a_d_resp, a_mem_en;
  logic [31:0] a_i_addr, a_i_rdata, a_d_addr, a_d_wdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_d_we, a_mem_we;
  logic [29:0] a_mem_addr;
  logic [15:0] a_cnt;
  logic [31:0] mem_a [256];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(a_rst),
    .i_req_valid(a_i_valid), .i_req_ready(a_i_ready), .i_addr(a_i_addr),
    .i_resp_valid(a_i_resp), .i_rdata(a_i_rdata),
    .d_req_valid(a_d_valid), .d_req_ready(a_d_ready), .d_we(a_d_we), .d_addr(a_d_addr),
    .d_wdata(a_d_wdata), .d_resp_valid(a_d_resp), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .conflict_cnt(a_cnt)
  );

  always @(posedge clk) begin
    if (a_mem_en) begin
      a_mem_rdata <= mem_a[a_mem_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (a_mem_we[b]) mem_a[a_mem_addr[7:0]][8*b +: 8] <= a_mem_wdata[8*b +: 8];
    end
  end

  // ---------------- DUT B: MEM_LAT=3, CNT_W=2 ----------------
  logic        b_rst, b_i_valid, b_i_ready, b_i_resp, b_d_valid, b_d_ready, b_d_resp, b_mem_en;
  logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_d_we, b_mem_we;
  logic [29:0] b_mem_addr;
  logic [1:0]  b_cnt;
  logic [31:0] mem_b [256];
  logic [31:0] b_pipe [3];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst(b_rst),
    .i_req_valid(b_i_valid), .i_req_ready(b_i_ready), .i_addr(b_i_addr),
    .i_resp_valid(b_i_resp), .i_rdata(b_i_rdata),
    .d_req_valid(b_d_valid), .d_req_ready(b_d_ready), .d_we(b_d_we), .d_addr(b_d_addr),
    .d_wdata(b_d_wdata), .d_resp_valid(b_d_resp), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .conflict_cnt(b_cnt)
  );

  assign b_mem_rdata = b_pipe[2];
  always @(posedge clk) begin
    b_pipe[0] <= b_mem_en ? mem_b[b_mem_addr[7:0]] : 32'h0;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
    if (b_mem_en)
      for (int b = 0; b < 4; b++)
        if (b_mem_we[b]) mem_b[b_mem_addr[7:0]][8*b +: 8] <= b_mem_wdata[8*b +: 8];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[0] = 32'h00500093; mem_a[1] = 32'h11111111;
    mem_b[0] = 32'h00500093; mem_b[1] = 32'h11111111;
    a_mem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) b_pipe[i] = 32'h0;
    a_rst = 1'b1; a_i_valid = 1'b1; a_i_addr = 32'h0;
    a_d_valid = 1'b0; a_d_we = 4'h0; a_d_addr = 32'h0; a_d_wdata = 32'h0;
    b_rst = 1'b1; b_i_valid = 1'b0; b_i_addr = 32'h0;
    b_d_valid = 1'b0; b_d_we = 4'h0; b_d_addr = 32'h0; b_d_wdata = 32'h0;

    // Reset: a pending request must not be granted while rst is high.
    step();
    chk("rst i_ready gated", a_i_ready, 0);
    chk("rst mem_en", a_mem_en, 0);
    step();
    chk("rst conflict_cnt", a_cnt, 0);
    chk("rst mem_addr", a_mem_addr, 0);
    chk("rst i_resp", a_i_resp, 0);
    chk("rst d_resp", a_d_resp, 0);

    // Fetch alone
    a_rst = 1'b0; #1;
    chk("t1 i_ready", a_i_ready, 1);
    chk("t1 mem_en", a_mem_en, 1);
    chk("t1 mem_we", a_mem_we, 0);
    step(); a_i_valid = 1'b0; #1;
    chk("t1 i_resp", a_i_resp, 1);
    chk("t1 i_rdata", a_i_rdata, 32'h00500093);
    chk("t1 busy no ready", a_i_ready, 0);
    step(); #1;
    chk("t1 resp pulse", a_i_resp, 0);

    // Tie: D wins, I next
    a_i_valid = 1'b1; a_i_addr = 32'h4; a_d_valid = 1'b1; a_d_addr = 32'h100; #1;
    chk("t2 d_ready", a_d_ready, 1);
    chk("t2 i_ready", a_i_ready, 0);
    chk("t2 mem_addr", a_mem_addr, 30'h40);
    step(); a_d_valid = 1'b0; #1;
    chk("t2 d_resp", a_d_resp, 1);
    chk("t2 d_rdata", a_d_rdata, 0);
    chk("t2 i_resp", a_i_resp, 0);
    chk("t2 conflict_cnt", a_cnt, 1);
    step(); #1;
    chk("t2 i_ready cyc2", a_i_ready, 1);
    chk("t2 i mem_addr", a_mem_addr, 30'h1);
    step(); a_i_valid = 1'b0; #1;
    chk("t2 i_resp", a_i_resp, 1);
    chk("t2 i_rdata", a_i_rdata, 32'h11111111);
    chk("t2 d_rdata held 0", a_d_rdata, 0);
    chk("t2 d_resp idle", a_d_resp, 0);
    step();

    // Byte-strobed store then load back
    a_d_valid = 1'b1; a_d_we = 4'b0011; a_d_wdata = 32'hAABBCCDD; #1;
    chk("t3 st ready", a_d_ready, 1);
    chk("t3 mem_we", a_mem_we, 4'b0011);
    chk("t3 mem_wdata", a_mem_wdata, 32'hAABBCCDD);
    step(); a_d_valid = 1'b0; a_d_we = 4'h0; #1;
    chk("t3 st resp", a_d_resp, 1);
    chk("t3 st rdata", a_d_rdata, 0);
    step(); a_d_valid = 1'b1; #1;
    chk("t3 ld ready", a_d_ready, 1);
    step(); a_d_valid = 1'b0; #1;
    chk("t3 ld rdata", a_d_rdata, 32'h0000CCDD);
    step();

    // Both held valid: last grant was D, so I, D, I, D, I
    a_i_valid = 1'b1; a_i_addr = 32'h0; a_d_valid = 1'b1; a_d_addr = 32'h100;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (k % 2 == 0) begin
        chk($sformatf("t4 i_ready k%0d", k), a_i_ready, (k % 4 == 0));
        chk($sformatf("t4 d_ready k%0d", k), a_d_ready, (k % 4 == 2));
      end else begin
        chk($sformatf("t4 busy k%0d", k), {a_i_ready, a_d_ready}, 2'b00);
        chk($sformatf("t4 resp k%0d", k), {a_i_resp, a_d_resp}, (k % 4 == 1) ? 2'b10 : 2'b01);
      end
      step();
    end
    a_i_valid = 1'b0; a_d_valid = 1'b0; #1;
    chk("t4 conflict_cnt", a_cnt, 6);

    // MEM_LAT=3 timing
    b_rst = 1'b0; b_i_valid = 1'b1; b_i_addr = 32'h0; #1;
    chk("b1 ready cyc0", b_i_ready, 1);
    step(); b_i_addr = 32'h4; #1;
    chk("b1 cyc1 ready/resp", {b_i_ready, b_i_resp}, 2'b00);
    step(); #1;
    chk("b1 cyc2 ready/resp", {b_i_ready, b_i_resp}, 2'b00);
    step(); #1;
    chk("b1 cyc3 ready/resp", {b_i_ready, b_i_resp}, 2'b01);
    chk("b1 cyc3 rdata", b_i_rdata, 32'h00500093);
    step(); #1;
    chk("b1 cyc4 ready", b_i_ready, 1);
    step(); b_i_valid = 1'b0;
    step();
    step(); #1;
    chk("b1 cyc7 resp", b_i_resp, 1);
    chk("b1 cyc7 rdata", b_i_rdata, 32'h11111111);
    step();

    // 4 conflict cycles on a 2-bit counter saturate at 3
    b_i_valid = 1'b1; b_i_addr = 32'h0; b_d_valid = 1'b1; b_d_addr = 32'h100;
    for (int k = 0; k < 16; k++) step();
    b_i_valid = 1'b0; b_d_valid = 1'b0; #1;
    chk("b2 conflict saturate", b_cnt, 3);

    // Reset in the middle of a D read
    b_i_valid = 1'b1; b_d_valid = 1'b1; #1;
    chk("b3 d_ready", b_d_ready, 1);
    step(); b_rst = 1'b1; b_d_valid = 1'b0; #1;
    chk("b3 rst ready gated", b_i_ready, 0);
    chk("b3 rst mem_en", b_mem_en, 0);
    step(); b_rst = 1'b0; #1;
    chk("b3 cyc2 grant", b_i_ready, 1);
    chk("b3 conflict cleared", b_cnt, 0);
    step(); b_i_valid = 1'b0; #1;
    chk("b3 cyc3 no resp", {b_i_resp, b_d_resp}, 2'b00);
    step(); #1;
    chk("b3 cyc4 no resp", {b_i_resp, b_d_resp}, 2'b00);
    step(); #1;
    chk("b3 cyc5 i_resp", {b_i_resp, b_d_resp}, 2'b10);
    chk("b3 cyc5 i_rdata", b_i_rdata, 32'h00500093);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
